// File: rtl/nibble_mayor_ctrl_if.sv
// ----------------------------------------------------------------------------
// nibble_mayor_ctrl_if
// Bundles the request/result signals of the serial magnitude comparator.
//
// Parameter
//   WIDTH        operand width in bits (2..16)
//
// Signals
//   nm_start     request to start one comparison (requester -> comparator)
//   nm_a, nm_b   operands, sampled when a start is accepted
//   nm_busy      high while bits are being compared
//   nm_done      one-cycle pulse marking a valid result
//   nm_selector  1 = nm_b greater, 0 = nm_a greater or equal operands
//   nm_distintos 1 = operands differ
//   nm_mayor     greater operand (common value when equal)
//   nm_ciclos    bit positions compared in the last operation
//
// Modports
//   master       requester side (drives start and operands)
//   slave        comparator side (drives status and results)
// ----------------------------------------------------------------------------
interface nibble_mayor_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             nm_start;
    logic [WIDTH-1:0] nm_a;
    logic [WIDTH-1:0] nm_b;
    logic             nm_busy;
    logic             nm_done;
    logic             nm_selector;
    logic             nm_distintos;
    logic [WIDTH-1:0] nm_mayor;
    logic [4:0]       nm_ciclos;

    modport master (
        output nm_start,
        output nm_a,
        output nm_b,
        input  nm_busy,
        input  nm_done,
        input  nm_selector,
        input  nm_distintos,
        input  nm_mayor,
        input  nm_ciclos
    );

    modport slave (
        input  nm_start,
        input  nm_a,
        input  nm_b,
        output nm_busy,
        output nm_done,
        output nm_selector,
        output nm_distintos,
        output nm_mayor,
        output nm_ciclos
    );
endinterface

// File: rtl/nibble_mayor_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_mayor_ctrl
// Serial magnitude comparator: compares two WIDTH-bit operands one bit per
// cycle, MSB first, and reports which one is greater, whether they differ,
// the greater value and how many bit positions were examined.
//
// Ports
//   CLK          single clock, rising edge
//   RESET        synchronous, active-high reset (wins over nm_start)
//   nm           nibble_mayor_ctrl_if.slave: start/operands in,
//                busy/done/selector/distintos/mayor/ciclos out
//
// Build option
//   NIBBLE_MAYOR_EARLY_EXIT_EN  when defined, a comparison ends right after
//                               the first differing bit; otherwise every
//                               comparison walks all WIDTH bits. Results are
//                               the same either way; only timing and
//                               nm_ciclos differ.
// ----------------------------------------------------------------------------
module nibble_mayor_ctrl #(
    parameter int WIDTH = 4
) (
    input logic                CLK,
    input logic                RESET,
    nibble_mayor_ctrl_if.slave nm
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             decided_reg, decided_next;
    logic             sel_reg, sel_next;
    logic [4:0]       ciclos_reg, ciclos_next;
    logic             sel_out_reg, sel_out_next;
    logic             dist_out_reg, dist_out_next;
    logic [WIDTH-1:0] mayor_out_reg, mayor_out_next;

    // Per-bit difference of the latched operands; the FSM looks at one
    // position of this vector per cycle.
    logic [WIDTH-1:0] diff_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_diff
            assign diff_vec[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    logic bit_differs;
    logic bit_b;
    logic finish_cmp;

    assign bit_differs = diff_vec[idx_reg];
    assign bit_b       = b_reg[idx_reg];

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        idx_next       = idx_reg;
        decided_next   = decided_reg;
        sel_next       = sel_reg;
        ciclos_next    = ciclos_reg;
        sel_out_next   = sel_out_reg;
        dist_out_next  = dist_out_reg;
        mayor_out_next = mayor_out_reg;
        finish_cmp     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (nm.nm_start) begin
                    a_next       = nm.nm_a;
                    b_next       = nm.nm_b;
                    idx_next     = IDX_TOP;
                    decided_next = 1'b0;
                    sel_next     = 1'b0;
                    ciclos_next  = 5'd0;
                    state_next   = CMP;
                end
            end

            CMP: begin
                ciclos_next = ciclos_reg + 5'd1;
                // Only the first differing bit decides; a set decided flag
                // locks the selector for the rest of the walk.
                if (!decided_reg && bit_differs) begin
                    decided_next = 1'b1;
                    sel_next     = bit_b;
                end
`ifdef NIBBLE_MAYOR_EARLY_EXIT_EN
                finish_cmp = (idx_reg == '0) || (!decided_reg && bit_differs);
`else
                finish_cmp = (idx_reg == '0);
`endif
                if (finish_cmp) begin
                    // Results are captured from this cycle's decision so the
                    // deciding bit is included even when it is the last one.
                    state_next     = DONE;
                    sel_out_next   = sel_next;
                    dist_out_next  = decided_next;
                    mayor_out_next = sel_next ? b_reg : a_reg;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            idx_reg       <= IDX_TOP;
            decided_reg   <= 1'b0;
            sel_reg       <= 1'b0;
            ciclos_reg    <= 5'd0;
            sel_out_reg   <= 1'b0;
            dist_out_reg  <= 1'b0;
            mayor_out_reg <= '0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            idx_reg       <= idx_next;
            decided_reg   <= decided_next;
            sel_reg       <= sel_next;
            ciclos_reg    <= ciclos_next;
            sel_out_reg   <= sel_out_next;
            dist_out_reg  <= dist_out_next;
            mayor_out_reg <= mayor_out_next;
        end
    end

    assign nm.nm_busy      = (state_reg == CMP);
    assign nm.nm_done      = (state_reg == DONE);
    assign nm.nm_selector  = sel_out_reg;
    assign nm.nm_distintos = dist_out_reg;
    assign nm.nm_mayor     = mayor_out_reg;
    assign nm.nm_ciclos    = ciclos_reg;

endmodule

// File: tb/tb_nibble_mayor_ctrl.sv
module tb_nibble_mayor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst8;

    nibble_mayor_ctrl_if #(.WIDTH(4)) bus4 ();
    nibble_mayor_ctrl_if #(.WIDTH(8)) bus8 ();

    nibble_mayor_ctrl #(.WIDTH(4)) u_dut4 (
        .CLK   (clk),
        .RESET (rst4),
        .nm    (bus4.slave)
    );

    nibble_mayor_ctrl #(.WIDTH(8)) u_dut8 (
        .CLK   (clk),
        .RESET (rst8),
        .nm    (bus8.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        sel;
        logic        dis;
        logic [15:0] mayor;
        logic [4:0]  cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4;
    exp_t e8;
    int   done4_cnt = 0;
    int   done8_cnt = 0;
    int   busy4 = 0;
    int   busy8 = 0;
    logic prev_done4 = 1'b0;
    logic prev_done8 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor for the 4-bit comparator: every nm_done pops one expected result.
    always @(negedge clk) begin
        if (prev_done4)
            check("w4_idle_after_done", 32'({bus4.nm_done, bus4.nm_busy}), 32'd0);
        if (bus4.nm_done) begin
            if (q4.size() == 0) begin
                total_cnt++;
                $display("FAIL w4_unexpected_done: got nm_done=1, required no pulse");
            end else begin
                e4 = q4.pop_front();
                check("w4_selector",  32'(bus4.nm_selector),  32'(e4.sel));
                check("w4_distintos", 32'(bus4.nm_distintos), 32'(e4.dis));
                check("w4_mayor",     32'(bus4.nm_mayor),     32'(e4.mayor));
                check("w4_ciclos",    32'(bus4.nm_ciclos),    32'(e4.cyc));
                check("w4_busy_len",  32'(busy4),             32'(e4.cyc));
                $display("w4 done: sel=%0b dis=%0b mayor=%0h ciclos=%0d busy=%0d",
                         bus4.nm_selector, bus4.nm_distintos, bus4.nm_mayor,
                         bus4.nm_ciclos, busy4);
            end
            done4_cnt++;
        end
        if (bus4.nm_busy) busy4++;
        else busy4 = 0;
        prev_done4 = bus4.nm_done;
    end

    // Monitor for the 8-bit comparator.
    always @(negedge clk) begin
        if (prev_done8)
            check("w8_idle_after_done", 32'({bus8.nm_done, bus8.nm_busy}), 32'd0);
        if (bus8.nm_done) begin
            if (q8.size() == 0) begin
                total_cnt++;
                $display("FAIL w8_unexpected_done: got nm_done=1, required no pulse");
            end else begin
                e8 = q8.pop_front();
                check("w8_selector",  32'(bus8.nm_selector),  32'(e8.sel));
                check("w8_distintos", 32'(bus8.nm_distintos), 32'(e8.dis));
                check("w8_mayor",     32'(bus8.nm_mayor),     32'(e8.mayor));
                check("w8_ciclos",    32'(bus8.nm_ciclos),    32'(e8.cyc));
                check("w8_busy_len",  32'(busy8),             32'(e8.cyc));
                $display("w8 done: sel=%0b dis=%0b mayor=%0h ciclos=%0d busy=%0d",
                         bus8.nm_selector, bus8.nm_distintos, bus8.nm_mayor,
                         bus8.nm_ciclos, busy8);
            end
            done8_cnt++;
        end
        if (bus8.nm_busy) busy8++;
        else busy8 = 0;
        prev_done8 = bus8.nm_done;
    end

    function automatic exp_t mk_exp(input logic sel, input logic dis, input logic [15:0] mayor,
                                    input logic [4:0] cyc_full, input logic [4:0] cyc_early);
        exp_t e;
        e.sel   = sel;
        e.dis   = dis;
        e.mayor = mayor;
`ifdef NIBBLE_MAYOR_EARLY_EXIT_EN
        e.cyc   = cyc_early;
`else
        e.cyc   = cyc_full;
`endif
        return e;
    endfunction

    task automatic wait_done4();
        int c0 = done4_cnt;
        int n  = 0;
        while (done4_cnt == c0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (done4_cnt == c0) begin
            total_cnt++;
            $display("FAIL w4_timeout: got no nm_done in 40 cycles, required one");
        end
    endtask

    task automatic wait_done8();
        int c0 = done8_cnt;
        int n  = 0;
        while (done8_cnt == c0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (done8_cnt == c0) begin
            total_cnt++;
            $display("FAIL w8_timeout: got no nm_done in 40 cycles, required one");
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sel, input logic dis,
                       input logic [3:0] mayor, input logic [4:0] cyc_full, input logic [4:0] cyc_early);
        q4.push_back(mk_exp(sel, dis, 16'(mayor), cyc_full, cyc_early));
        @(negedge clk);
        bus4.nm_a     = a;
        bus4.nm_b     = b;
        bus4.nm_start = 1'b1;
        @(negedge clk);
        bus4.nm_start = 1'b0;
        wait_done4();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst4 = 1'b1;
        rst8 = 1'b1;
        // Start held during reset must be ignored (reset has priority).
        bus4.nm_start = 1'b1;
        bus4.nm_a     = 4'hF;
        bus4.nm_b     = 4'h0;
        bus8.nm_start = 1'b0;
        bus8.nm_a     = 8'h00;
        bus8.nm_b     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(bus4.nm_busy),      32'd0);
        check("rst_done",      32'(bus4.nm_done),      32'd0);
        check("rst_selector",  32'(bus4.nm_selector),  32'd0);
        check("rst_distintos", 32'(bus4.nm_distintos), 32'd0);
        check("rst_mayor",     32'(bus4.nm_mayor),     32'd0);
        check("rst_ciclos",    32'(bus4.nm_ciclos),    32'd0);
        check("rst8_mayor",    32'(bus8.nm_mayor),     32'd0);
        bus4.nm_start = 1'b0;
        rst4 = 1'b0;
        rst8 = 1'b0;

        //   a        b        sel   dis   mayor    full  early
        op4(4'b1010, 4'b0111, 1'b0, 1'b1, 4'b1010, 5'd4, 5'd1);
        op4(4'b0011, 4'b1000, 1'b1, 1'b1, 4'b1000, 5'd4, 5'd1);
        op4(4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0110, 5'd4, 5'd4);
        op4(4'b0101, 4'b0110, 1'b1, 1'b1, 4'b0110, 5'd4, 5'd3);
        op4(4'b1110, 4'b1111, 1'b1, 1'b1, 4'b1111, 5'd4, 5'd4);
        op4(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 5'd4, 5'd4);

        // Start held high: operands changed mid-operation must not be latched,
        // the DONE-cycle start is dropped, and the old result holds during the
        // second comparison.
        q4.push_back(mk_exp(1'b0, 1'b1, 16'h000C, 5'd4, 5'd1));
        q4.push_back(mk_exp(1'b1, 1'b1, 16'h0004, 5'd4, 5'd2));
        @(negedge clk);
        bus4.nm_a     = 4'b1100;
        bus4.nm_b     = 4'b0100;
        bus4.nm_start = 1'b1;
        @(negedge clk);
        bus4.nm_a = 4'b0010;
        bus4.nm_b = 4'b0100;
        wait_done4();
        @(negedge clk);
        check("held_idle_busy", 32'(bus4.nm_busy), 32'd0);
        @(negedge clk);
        check("held_cmp_busy",  32'(bus4.nm_busy),      32'd1);
        check("held_mayor",     32'(bus4.nm_mayor),     32'h0C);
        check("held_selector",  32'(bus4.nm_selector),  32'd0);
        check("held_distintos", 32'(bus4.nm_distintos), 32'd1);
        bus4.nm_start = 1'b0;
        wait_done4();

        // Reset in the second CMP cycle aborts with no done pulse.
        c0 = done4_cnt;
        @(negedge clk);
`ifdef NIBBLE_MAYOR_EARLY_EXIT_EN
        bus4.nm_a = 4'hF;
        bus4.nm_b = 4'hF;
`else
        bus4.nm_a = 4'hF;
        bus4.nm_b = 4'h0;
`endif
        bus4.nm_start = 1'b1;
        @(negedge clk);
        bus4.nm_start = 1'b0;
        check("abort_busy_c1", 32'(bus4.nm_busy), 32'd1);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        check("abort_busy",      32'(bus4.nm_busy),      32'd0);
        check("abort_done",      32'(bus4.nm_done),      32'd0);
        check("abort_selector",  32'(bus4.nm_selector),  32'd0);
        check("abort_distintos", 32'(bus4.nm_distintos), 32'd0);
        check("abort_mayor",     32'(bus4.nm_mayor),     32'd0);
        check("abort_ciclos",    32'(bus4.nm_ciclos),    32'd0);
        rst4 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done4_cnt), 32'(c0));
        op4(4'b0100, 4'b1000, 1'b1, 1'b1, 4'b1000, 5'd4, 5'd1);

        // 8-bit instance.
        q8.push_back(mk_exp(1'b0, 1'b1, 16'h0080, 5'd8, 5'd1));
        @(negedge clk);
        bus8.nm_a     = 8'h80;
        bus8.nm_b     = 8'h7F;
        bus8.nm_start = 1'b1;
        @(negedge clk);
        bus8.nm_start = 1'b0;
        wait_done8();

        repeat (2) @(negedge clk);
        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q8_empty", 32'(q8.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
